// File: rtl/taxi_pkg.sv
// Shared taxi-meter definitions: FSM states, ride mode codes and default fare constants.
package taxi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] MODE_IDLE    = 2'b00;
    localparam logic [1:0] MODE_NORMAL  = 2'b01;
    localparam logic [1:0] MODE_PREMIUM = 2'b10;

    localparam int DEF_BASE_N_TENS = 3;
    localparam int DEF_BASE_N_ONES = 8;
    localparam int DEF_BASE_P_TENS = 6;
    localparam int DEF_BASE_P_ONES = 5;
    localparam int DEF_INC_N       = 1;
    localparam int DEF_INC_P       = 2;

    // Five BCD digits, index 0 = least significant.
    typedef logic [4:0][3:0] fare_t;

    function automatic fare_t base_fare(input int tens, input int ones);
        fare_t f;
        f    = '0;
        f[1] = 4'(tens);
        f[0] = 4'(ones);
        return f;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One decimal digit of a ripple BCD adder: digit + addend + carry-in, corrected back into 0..9.
module bcd_digit_add (
    input  logic [3:0] digit,
    input  logic [3:0] addend,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);

    logic [4:0] raw;
    logic [4:0] adj;

    always_comb begin
        raw = {1'b0, digit} + {1'b0, addend} + {4'b0000, carry_in};
        adj = raw - 5'd10;
        if (raw > 5'd9) begin
            sum       = adj[3:0];
            carry_out = 1'b1;
        end else begin
            sum       = raw[3:0];
            carry_out = 1'b0;
        end
    end

endmodule

// File: rtl/taxi_fare_acc.sv
// Taxi fare accumulator: counts synchronised meter pulses into a saturating 5-digit BCD fare.
// Meter rise to digit update is 3 clk (2-flop sync + edge detect); start/stop take effect next cycle.
module taxi_fare_acc
    import taxi_pkg::*;
#(
    parameter int BASE_N_TENS = DEF_BASE_N_TENS,
    parameter int BASE_N_ONES = DEF_BASE_N_ONES,
    parameter int BASE_P_TENS = DEF_BASE_P_TENS,
    parameter int BASE_P_ONES = DEF_BASE_P_ONES,
    parameter int INC_N       = DEF_INC_N,
    parameter int INC_P       = DEF_INC_P
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       normal,
    input  logic       premium,
    input  logic       stop,
    input  logic       meter,
    output logic [3:0] fare_d0,
    output logic [3:0] fare_d1,
    output logic [3:0] fare_d2,
    output logic [3:0] fare_d3,
    output logic [3:0] fare_d4,
    output logic [1:0] mode,
    output logic       running,
    output logic       sat
);

    localparam logic [3:0] INC_N_D = 4'(INC_N);
    localparam logic [3:0] INC_P_D = 4'(INC_P);

    state_t     state_q, state_d;
    fare_t      digits_q, digits_d, digits_sum;
    logic [1:0] mode_q, mode_d;
    logic       sat_q, sat_d;
    logic       m_s1, m_s2, m_prev;
    logic       tick;
    logic [3:0] inc;
    logic [5:0] carry;

    assign tick     = m_s2 & ~m_prev;
    assign inc      = (mode_q == MODE_PREMIUM) ? INC_P_D : INC_N_D;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < 5; i++) begin : g_add
        bcd_digit_add u_add (
            .digit     (digits_q[i]),
            .addend    ((i == 0) ? inc : 4'd0),
            .carry_in  (carry[i]),
            .sum       (digits_sum[i]),
            .carry_out (carry[i+1])
        );
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        mode_d   = mode_q;
        sat_d    = sat_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (normal) begin
                    state_d  = ST_RUN;
                    mode_d   = MODE_NORMAL;
                    digits_d = base_fare(BASE_N_TENS, BASE_N_ONES);
                    sat_d    = 1'b0;
                end else if (premium) begin
                    state_d  = ST_RUN;
                    mode_d   = MODE_PREMIUM;
                    digits_d = base_fare(BASE_P_TENS, BASE_P_ONES);
                    sat_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_HOLD;
                end else if (tick) begin
                    // Carry out of the top digit means the fare passed 99999.
                    if (carry[5]) begin
                        digits_d = {5{4'd9}};
                        sat_d    = 1'b1;
                    end else begin
                        digits_d = digits_sum;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            digits_q <= '0;
            mode_q   <= MODE_IDLE;
            sat_q    <= 1'b0;
            m_s1     <= 1'b0;
            m_s2     <= 1'b0;
            m_prev   <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            mode_q   <= mode_d;
            sat_q    <= sat_d;
            m_s1     <= meter;
            m_s2     <= m_s1;
            // Tracking m_s2 every cycle also covers RUN entry, so a meter already high never charges.
            m_prev   <= m_s2;
        end
    end

    assign fare_d0 = digits_q[0];
    assign fare_d1 = digits_q[1];
    assign fare_d2 = digits_q[2];
    assign fare_d3 = digits_q[3];
    assign fare_d4 = digits_q[4];
    assign mode    = mode_q;
    assign running = (state_q == ST_RUN);
    assign sat     = sat_q;

endmodule

// File: tb/tb_taxi_fare_acc.sv
// Scoreboard bench for taxi_fare_acc: stimulus tasks update an integer fare model and queue expectations.
module tb_taxi_fare_acc;

    localparam int TB_INC_N  = 1;
    localparam int TB_INC_P  = 9;
    localparam int TB_BASE_N = 38;
    localparam int TB_BASE_P = 65;
    localparam int FARE_MAX  = 99999;

    logic       clk = 1'b0;
    logic       reset, normal, premium, stop, meter;
    logic [3:0] fare_d0, fare_d1, fare_d2, fare_d3, fare_d4;
    logic [1:0] mode;
    logic       running, sat;

    always #5 clk = ~clk;

    taxi_fare_acc #(
        .BASE_N_TENS (3),
        .BASE_N_ONES (8),
        .BASE_P_TENS (6),
        .BASE_P_ONES (5),
        .INC_N       (TB_INC_N),
        .INC_P       (TB_INC_P)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .normal  (normal),
        .premium (premium),
        .stop    (stop),
        .meter   (meter),
        .fare_d0 (fare_d0),
        .fare_d1 (fare_d1),
        .fare_d2 (fare_d2),
        .fare_d3 (fare_d3),
        .fare_d4 (fare_d4),
        .mode    (mode),
        .running (running),
        .sat     (sat)
    );

    typedef struct {
        int cyc;
        int fare;
        int md;
        bit run;
        bit st;
    } exp_t;

    exp_t  exp_q[$];
    string lbl_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    passed = 0;

    // Behavioural model: ride phase (0 idle, 1 riding, 2 stopped), fare in 100-won units.
    int m_phase = 0;
    int m_fare  = 0;
    int m_mode  = 0;
    bit m_sat   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    exp_t  e;
    string l;
    int    act_fare;
    bit    bad_bcd;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            bad_bcd  = (fare_d0 > 9) || (fare_d1 > 9) || (fare_d2 > 9) || (fare_d3 > 9) || (fare_d4 > 9);
            act_fare = int'(fare_d4) * 10000 + int'(fare_d3) * 1000 + int'(fare_d2) * 100
                     + int'(fare_d1) * 10 + int'(fare_d0);
            checks++;
            if (e.cyc != cyc) begin
                $display("FAIL %s: expectation for cycle %0d reached only at cycle %0d", l, e.cyc, cyc);
            end else if (!bad_bcd && act_fare == e.fare && int'(mode) == e.md
                         && running == e.run && sat == e.st) begin
                passed++;
            end else begin
                $display("FAIL %s @%0d: got fare=%0d (digits %0d%0d%0d%0d%0d) mode=%0d running=%0b sat=%0b, expected fare=%0d mode=%0d running=%0b sat=%0b",
                         l, cyc, act_fare, fare_d4, fare_d3, fare_d2, fare_d1, fare_d0, mode, running, sat,
                         e.fare, e.md, e.run, e.st);
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int delay, input string lbl);
        exp_t x;
        x.cyc  = cyc + delay;
        x.fare = m_fare;
        x.md   = m_mode;
        x.run  = (m_phase == 1);
        x.st   = m_sat;
        exp_q.push_back(x);
        lbl_q.push_back(lbl);
    endtask

    task automatic model_reset();
        m_phase = 0; m_fare = 0; m_mode = 0; m_sat = 1'b0;
    endtask

    task automatic do_start(input bit n, input bit p, input string lbl);
        normal  = n;
        premium = p;
        if (m_phase != 1 && (n || p)) begin
            m_phase = 1;
            m_mode  = n ? 1 : 2;
            m_fare  = n ? TB_BASE_N : TB_BASE_P;
            m_sat   = 1'b0;
        end
        push_exp(1, lbl);
        clk_n(1);
        normal  = 1'b0;
        premium = 1'b0;
    endtask

    // stop optionally together with normal; stop has priority while riding.
    task automatic do_stop(input bit with_normal, input string lbl);
        stop   = 1'b1;
        normal = with_normal;
        if (m_phase == 1) m_phase = 2;
        else if (with_normal) begin
            m_phase = 1; m_mode = 1; m_fare = TB_BASE_N; m_sat = 1'b0;
        end
        push_exp(1, lbl);
        clk_n(1);
        stop   = 1'b0;
        normal = 1'b0;
    endtask

    task automatic do_pulse(input int hi, input int lo, input bit pre_chk, input string lbl);
        meter = 1'b1;
        if (pre_chk) push_exp(2, {lbl, "_not_yet"});
        if (m_phase == 1) begin
            m_fare += (m_mode == 2) ? TB_INC_P : TB_INC_N;
            if (m_fare > FARE_MAX) begin
                m_fare = FARE_MAX;
                m_sat  = 1'b1;
            end
        end
        push_exp(3, lbl);
        clk_n(hi);
        meter = 1'b0;
        clk_n(lo);
    endtask

    initial begin
        reset = 1'b1; normal = 1'b0; premium = 1'b0; stop = 1'b0; meter = 1'b0;
        model_reset();
        clk_n(3);
        push_exp(0, "reset_state");
        clk_n(1);
        reset = 1'b0;
        clk_n(2);

        // Normal ride, one pulse lands exactly 3 clk after the rise.
        do_start(1'b1, 1'b0, "normal_base");
        do_pulse(2, 2, 1'b1, "normal_first_tick");
        do_stop(1'b0, "stop_1");

        // Meter held high while idle must not charge on premium entry.
        meter = 1'b1;
        clk_n(6);
        do_start(1'b0, 1'b1, "premium_base_meter_high");
        clk_n(4);
        push_exp(0, "premium_no_spurious_tick");
        meter = 1'b0;
        clk_n(2);
        do_pulse(2, 2, 1'b0, "premium_first_tick");
        do_stop(1'b0, "stop_2");

        // Premium ride with 18 pulses: carries ripple through several digits.
        do_start(1'b0, 1'b1, "premium_base_2");
        for (int i = 0; i < 18; i++)
            do_pulse($urandom_range(2, 4), $urandom_range(2, 4), 1'b0, "premium_carry");

        // Normal ride, 5 ticks, stop coincident with a tick, then ignored ticks and a restart.
        do_stop(1'b0, "stop_3");
        do_start(1'b1, 1'b0, "normal_base_2");
        for (int i = 0; i < 5; i++) do_pulse(2, 2, 1'b0, "normal_5_ticks");
        meter = 1'b1;
        clk_n(2);
        stop = 1'b1;
        m_phase = 2;
        push_exp(1, "stop_with_tick");
        clk_n(1);
        stop  = 1'b0;
        meter = 1'b0;
        clk_n(2);
        for (int i = 0; i < 3; i++) do_pulse(2, 3, 1'b0, "hold_ticks_ignored");
        do_start(1'b0, 1'b0, "hold_idle_cycle");
        do_start(1'b1, 1'b1, "both_normal_wins");
        do_start(1'b0, 1'b1, "premium_ignored_in_run");
        do_stop(1'b1, "stop_beats_normal");
        do_start(1'b1, 1'b0, "normal_from_hold");
        do_stop(1'b0, "stop_4");

        // Saturation: premium fare climbs past 99999 and clamps.
        do_start(1'b0, 1'b1, "sat_ride_base");
        for (int i = 0; i < 11105; i++) do_pulse(2, 2, 1'b0, "sat_ride_tick");
        do_stop(1'b0, "sat_hold");
        do_start(1'b1, 1'b0, "sat_cleared_by_load");

        // Reset mid-ride with a rise still in the synchronizer.
        do_pulse(2, 2, 1'b0, "pre_reset_tick");
        meter = 1'b1;
        clk_n(1);
        reset = 1'b1;
        model_reset();
        push_exp(1, "reset_mid_run");
        clk_n(1);
        reset = 1'b0;
        clk_n(4);
        push_exp(0, "no_tick_after_reset");
        meter = 1'b0;
        clk_n(3);

        // Random mix of starts, stops and pulses.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0:       do_start(1'b1, 1'b0, "rnd_normal");
                1:       do_start(1'b0, 1'b1, "rnd_premium");
                2:       do_start(1'b1, 1'b1, "rnd_both");
                3:       do_stop(1'b0, "rnd_stop");
                4:       if (m_phase == 1) do_stop(1'b1, "rnd_stop_normal");
                         else clk_n($urandom_range(1, 3));
                default: do_pulse($urandom_range(2, 4), $urandom_range(2, 4), 1'b0, "rnd_pulse");
            endcase
        end

        clk_n(6);
        while (exp_q.size() > 0) begin
            checks++;
            $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
                     lbl_q[0], exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
            void'(lbl_q.pop_front());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
